// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
//
// Flow: IDLE grants one requester (search starts after the last grant), registers its request,
// drives it onto the ALU for one EXEC cycle, then holds the captured result in RESP until the
// consumer accepts it. Unimplemented opcodes skip EXEC and answer with err=1.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   req_valid/req_ready [NUM_REQ]       per-requester handshake (req_ready is one-hot or zero)
//   req_ctrl/req_a/req_b                flattened per-requester opcode and operands (slice i)
//   resp_valid/resp_ready               response handshake
//   resp_id, resp_c, resp_zero/over/cout, resp_err   tagged response payload
//   alu_ctrl/alu_a/alu_b                drive the external ALU
//   alu_c, alu_zero/alu_over/alu_c_out  ALU result and flags
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_BITS  = 4,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*CTRL_BITS-1:0]  req_ctrl,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_W-1:0]               resp_id,
  output logic [DATA_WIDTH-1:0]         resp_c,
  output logic                          resp_zero,
  output logic                          resp_over,
  output logic                          resp_cout,
  output logic                          resp_err,
  output logic [CTRL_BITS-1:0]          alu_ctrl,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  input  logic [DATA_WIDTH-1:0]         alu_c,
  input  logic                          alu_zero,
  input  logic                          alu_over,
  input  logic                          alu_c_out
);

  localparam logic [CTRL_BITS-1:0] OpAnd = CTRL_BITS'(4'b0000);
  localparam logic [CTRL_BITS-1:0] OpOr  = CTRL_BITS'(4'b0011);
  localparam logic [CTRL_BITS-1:0] OpAdd = CTRL_BITS'(4'b0010);
  localparam logic [CTRL_BITS-1:0] OpSub = CTRL_BITS'(4'b0110);
  localparam logic [CTRL_BITS-1:0] OpSlt = CTRL_BITS'(4'b0111);
  localparam logic [CTRL_BITS-1:0] OpSge = CTRL_BITS'(4'b0101);
  localparam logic [CTRL_BITS-1:0] OpNor = CTRL_BITS'(4'b1100);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                r_state, w_state_next;
  logic [ID_W-1:0]       r_last_grant;
  logic [ID_W-1:0]       r_id;
  logic [CTRL_BITS-1:0]  r_ctrl;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_c;
  logic                  r_zero, r_over, r_cout, r_err;

  // Unflattened views of the request buses.
  logic [CTRL_BITS-1:0]  w_ctrl_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_a_arr    [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_b_arr    [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_ctrl_arr[g] = req_ctrl[g*CTRL_BITS +: CTRL_BITS];
    assign w_a_arr[g]    = req_a[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_arr[g]    = req_b[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic            w_found;
  logic [ID_W-1:0] w_gnt;
  logic [ID_W-1:0] w_cand;
  logic            w_accept;
  logic            w_legal;

  // Round-robin search: first valid requester starting at last_grant+1, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_W'((32'(r_last_grant) + 32'd1 + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  // rst_n gates req_ready so nothing looks accepted while reset is held.
  assign w_accept = (r_state == StIdle) && w_found && rst_n;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt] = 1'b1;
  end

  assign w_legal = w_ctrl_arr[w_gnt] inside {OpAnd, OpOr, OpAdd, OpSub, OpSlt, OpSge, OpNor};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = w_legal ? StExec : StResp;
      StExec:  w_state_next = StResp;
      StResp:  if (resp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_ctrl       <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_zero       <= 1'b0;
      r_over       <= 1'b0;
      r_cout       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_gnt;
        r_id         <= w_gnt;
        if (w_legal) begin
          r_ctrl <= w_ctrl_arr[w_gnt];
          r_a    <= w_a_arr[w_gnt];
          r_b    <= w_b_arr[w_gnt];
        end else begin
          // Illegal ops bypass the ALU; operand registers keep the last issued op.
          r_c    <= '0;
          r_zero <= 1'b0;
          r_over <= 1'b0;
          r_cout <= 1'b0;
          r_err  <= 1'b1;
        end
      end
      if (r_state == StExec) begin
        r_c    <= alu_c;
        r_zero <= alu_zero;
        r_over <= alu_over;
        r_cout <= alu_c_out;
        r_err  <= 1'b0;
      end
    end
  end

  assign alu_ctrl   = r_ctrl;
  assign alu_a      = r_a;
  assign alu_b      = r_b;

  assign resp_valid = (r_state == StResp);
  assign resp_id    = r_id;
  assign resp_c     = r_c;
  assign resp_zero  = r_zero;
  assign resp_over  = r_over;
  assign resp_cout  = r_cout;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and a transaction-level model.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int CB = 4;
  localparam int NR = 4;
  localparam int IW = 2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SGE = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef struct packed {
    logic [DW-1:0] c;
    logic          zero;
    logic          over;
    logic          cout;
    logic          err;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*CB-1:0] req_ctrl;
  logic [NR*DW-1:0] req_a, req_b;
  logic             resp_valid, resp_ready;
  logic [IW-1:0]    resp_id;
  logic [DW-1:0]    resp_c;
  logic             resp_zero, resp_over, resp_cout, resp_err;
  logic [CB-1:0]    alu_ctrl;
  logic [DW-1:0]    alu_a, alu_b, alu_c;
  logic             alu_zero, alu_over, alu_c_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: last granted requester and the last op issued to the ALU.
  int          model_last = NR - 1;
  logic [3:0]  m_alu_ctrl = '0;
  logic [31:0] m_alu_a    = '0;
  logic [31:0] m_alu_b    = '0;
  logic [3:0]  p_ctrl [NR];
  logic [31:0] p_a    [NR];
  logic [31:0] p_b    [NR];

  alu_arbiter #(
    .DATA_WIDTH(DW),
    .CTRL_BITS (CB),
    .NUM_REQ   (NR),
    .ID_W      (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_c    (resp_c),
    .resp_zero (resp_zero),
    .resp_over (resp_over),
    .resp_cout (resp_cout),
    .resp_err  (resp_err),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_zero  (alu_zero),
    .alu_over  (alu_over),
    .alu_c_out (alu_c_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic resp_t alu_fn(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    resp_t       r;
    logic [32:0] s;
    r = '0;
    s = '0;
    case (ctrl)
      OP_AND: r.c = a & b;
      OP_OR:  r.c = a | b;
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r.c = s[31:0];
        r.cout = s[32];
        r.over = (a[31] == b[31]) && (r.c[31] != a[31]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.c = s[31:0];
        r.cout = s[32];
        r.over = (a[31] != b[31]) && (r.c[31] != a[31]);
      end
      OP_SLT: r.c = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      OP_SGE: r.c = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      OP_NOR: r.c = ~(a | b);
      default: r.c = 32'hDEAD_BEEF;
    endcase
    r.zero = (r.c == 32'd0);
    return r;
  endfunction

  resp_t alu_r;
  always_comb alu_r = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_c     = alu_r.c;
  assign alu_zero  = alu_r.zero;
  assign alu_over  = alu_r.over;
  assign alu_c_out = alu_r.cout;

  function automatic logic is_legal(input logic [3:0] ctrl);
    return ctrl inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SGE, OP_NOR};
  endfunction

  function automatic resp_t model_resp(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    resp_t r;
    r = '0;
    if (is_legal(ctrl)) r = alu_fn(ctrl, a, b);
    else                r.err = 1'b1;
    return r;
  endfunction

  function automatic int model_grant(input logic [NR-1:0] mask, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (mask[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [3:0] rand_legal();
    logic [3:0] ops [7];
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SGE, OP_NOR};
    return ops[$urandom_range(6)];
  endfunction

  function automatic logic [3:0] rand_illegal();
    logic [3:0] v;
    do v = 4'($urandom_range(15)); while (is_legal(v));
    return v;
  endfunction

  task automatic set_req(input int i, input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    p_ctrl[i] = ctrl;
    p_a[i]    = a;
    p_b[i]    = b;
    req_ctrl[i*CB +: CB] = ctrl;
    req_a[i*DW +: DW]    = a;
    req_b[i*DW +: DW]    = b;
    req_valid[i]         = 1'b1;
  endtask

  // Bounded wait for a request handshake; id = -1 on timeout.
  task automatic wait_hs(output int id, output int hcyc);
    id   = -1;
    hcyc = -1;
    for (int k = 0; k < 40 && hcyc < 0; k++) begin
      @(negedge clk); #1;
      if ((req_valid & req_ready) != '0) begin
        for (int i = 0; i < NR; i++) if (req_ready[i]) id = i;
        hcyc = cyc;
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
      end
    end
  endtask

  task automatic wait_resp(output int rcyc);
    rcyc = -1;
    for (int k = 0; k < 40 && rcyc < 0; k++) begin
      @(negedge clk); #1;
      if (resp_valid) rcyc = cyc;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, rand_legal(), $urandom, $urandom);
    #3;
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid);
    end
    checks++;
    if ({resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err} !== '0) begin
      errors++; $display("FAIL reset_resp_fields: id %0d c %0h flags %b%b%b%b expected all 0",
                         resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err);
    end
    checks++;
    if ({alu_ctrl, alu_a, alu_b} !== '0) begin
      errors++; $display("FAIL reset_alu: ctrl %b a %0h b %0h expected 0", alu_ctrl, alu_a, alu_b);
    end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    int id, h, r;
    resp_ready = 1'b1;
    set_req(0, OP_ADD, 32'd75, 32'd25);
    wait_hs(id, h);
    checks++;
    if (id != 0) begin errors++; $display("FAIL add_grant: got %0d expected 0", id); end
    model_last = 0;
    {m_alu_ctrl, m_alu_a, m_alu_b} = {OP_ADD, 32'd75, 32'd25};
    wait_resp(r);
    checks++;
    if (h < 0 || r - h != 2) begin
      errors++; $display("FAIL add_latency: got %0d expected 2", r - h);
    end
    checks++;
    if (resp_id !== 2'd0) begin errors++; $display("FAIL add_id: got %0d expected 0", resp_id); end
    checks++;
    if ({resp_c, resp_zero, resp_over, resp_err} !== {32'd100, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_result: got c %0d z%b o%b e%b expected c 100 z0 o0 e0",
                         resp_c, resp_zero, resp_over, resp_err);
    end
    checks++;
    if ({alu_ctrl, alu_a, alu_b} !== {m_alu_ctrl, m_alu_a, m_alu_b}) begin
      errors++; $display("FAIL add_alu_drive: got %b %0h %0h expected %b %0h %0h",
                         alu_ctrl, alu_a, alu_b, m_alu_ctrl, m_alu_a, m_alu_b);
    end
    finish_resp();
  endtask

  task automatic test_sub_zero();
    int id, h, r;
    resp_ready = 1'b1;
    set_req(2, OP_SUB, 32'd1, 32'd1);
    wait_hs(id, h);
    model_last = 2;
    wait_resp(r);
    checks++;
    if (id != 2 || resp_id !== 2'd2) begin
      errors++; $display("FAIL sub_id: grant %0d resp_id %0d expected 2", id, resp_id);
    end
    checks++;
    if ({resp_c, resp_zero, resp_over, resp_cout, resp_err} !== {32'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_zero: got c %0h z%b o%b co%b e%b expected c 0 z1 o0 co1 e0",
                         resp_c, resp_zero, resp_over, resp_cout, resp_err);
    end
    finish_resp();
    set_req(3, OP_ADD, 32'h8000_0000, 32'h8000_0000);
    wait_hs(id, h);
    model_last = 3;
    {m_alu_ctrl, m_alu_a, m_alu_b} = {OP_ADD, 32'h8000_0000, 32'h8000_0000};
    wait_resp(r);
    checks++;
    if ({resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err} !==
        {2'd3, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_overflow: got id %0d c %0h z%b o%b co%b e%b expected id 3 c 0 z1 o1 co1 e0",
                         resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err);
    end
    finish_resp();
  endtask

  task automatic test_round_robin();
    int id, h, r, exp_id, prev_h;
    resp_t exp;
    resp_ready = 1'b1;
    prev_h = -1;
    for (int i = 0; i < NR; i++) set_req(i, rand_legal(), $urandom, $urandom);
    for (int t = 0; t < 8; t++) begin
      exp_id = model_grant(req_valid, model_last);
      exp = model_resp(p_ctrl[exp_id], p_a[exp_id], p_b[exp_id]);
      {m_alu_ctrl, m_alu_a, m_alu_b} = {p_ctrl[exp_id], p_a[exp_id], p_b[exp_id]};
      model_last = exp_id;
      wait_hs(id, h);
      set_req(exp_id, rand_legal(), $urandom, $urandom);
      checks++;
      if (id != exp_id) begin errors++; $display("FAIL rr_grant: got %0d expected %0d", id, exp_id); end
      if (t > 0) begin
        checks++;
        if (h - prev_h != 3) begin
          errors++; $display("FAIL rr_throughput: got %0d cycles expected 3", h - prev_h);
        end
      end
      prev_h = h;
      wait_resp(r);
      checks++;
      if ({resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err} !== {IW'(exp_id), exp}) begin
        errors++; $display("FAIL rr_resp: got id %0d c %0h flags %b%b%b%b expected id %0d c %0h flags %b%b%b%b",
                           resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err,
                           exp_id, exp.c, exp.zero, exp.over, exp.cout, exp.err);
      end
      finish_resp();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int id, h, r, rhs, exp_id;
    resp_t exp;
    resp_ready = 1'b0;
    set_req(1, rand_legal(), $urandom, $urandom);
    exp_id = model_grant(req_valid, model_last);
    exp = model_resp(p_ctrl[1], p_a[1], p_b[1]);
    {m_alu_ctrl, m_alu_a, m_alu_b} = {p_ctrl[1], p_a[1], p_b[1]};
    model_last = exp_id;
    wait_hs(id, h);
    checks++;
    if (id != 1 || exp_id != 1) begin errors++; $display("FAIL bp_grant: got %0d expected 1", id); end
    for (int i = 0; i < NR; i++) if (i != 1) set_req(i, rand_legal(), $urandom, $urandom);
    wait_resp(r);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++;
      if (resp_valid !== 1'b1 || {resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err} !== {2'd1, exp}) begin
        errors++; $display("FAIL bp_hold: cycle %0d got v%b id %0d c %0h expected v1 id 1 c %0h",
                           k, resp_valid, resp_id, resp_c, exp.c);
      end
      checks++;
      if (req_ready !== '0) begin errors++; $display("FAIL bp_req_ready: got %b expected 0", req_ready); end
      checks++;
      if ({alu_ctrl, alu_a, alu_b} !== {m_alu_ctrl, m_alu_a, m_alu_b}) begin
        errors++; $display("FAIL bp_alu_hold: got %b %0h %0h expected %b %0h %0h",
                           alu_ctrl, alu_a, alu_b, m_alu_ctrl, m_alu_a, m_alu_b);
      end
    end
    rhs = cyc;
    finish_resp();
    // Drain the requests that queued up during the stall, back to back.
    while (req_valid != '0) begin
      exp_id = model_grant(req_valid, model_last);
      exp = model_resp(p_ctrl[exp_id], p_a[exp_id], p_b[exp_id]);
      {m_alu_ctrl, m_alu_a, m_alu_b} = {p_ctrl[exp_id], p_a[exp_id], p_b[exp_id]};
      model_last = exp_id;
      wait_hs(id, h);
      checks++;
      if (id != exp_id || h != rhs + 1) begin
        errors++; $display("FAIL b2b_accept: got id %0d cycle %0d expected id %0d cycle %0d",
                           id, h, exp_id, rhs + 1);
        if (id < 0) req_valid = '0;
      end
      wait_resp(r);
      checks++;
      if ({resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err} !== {IW'(exp_id), exp}) begin
        errors++; $display("FAIL b2b_resp: got id %0d c %0h expected id %0d c %0h",
                           resp_id, resp_c, exp_id, exp.c);
      end
      rhs = cyc;
      finish_resp();
    end
  endtask

  task automatic test_illegal();
    int id, h, r, rq, exp_id;
    logic [3:0]  op;
    logic [31:0] a, b;
    resp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      op = (t == 0) ? 4'b1111 : (t == 1) ? 4'b0001 : rand_illegal();
      rq = (t == 0) ? 1 : int'($urandom_range(NR - 1));
      a  = (t == 0) ? 32'd5 : $urandom;
      b  = (t == 0) ? 32'd3 : $urandom;
      set_req(rq, op, a, b);
      exp_id = model_grant(req_valid, model_last);
      model_last = exp_id;
      wait_hs(id, h);
      wait_resp(r);
      checks++;
      if (id != exp_id || h < 0 || r - h != 1) begin
        errors++; $display("FAIL ill_latency: got id %0d latency %0d expected id %0d latency 1",
                           id, r - h, exp_id);
      end
      checks++;
      if ({resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err} !== {IW'(exp_id), 32'd0, 4'b0001}) begin
        errors++; $display("FAIL ill_resp: got id %0d c %0h flags %b%b%b%b expected id %0d c 0 flags 0001",
                           resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err, exp_id);
      end
      checks++;
      if ({alu_ctrl, alu_a, alu_b} !== {m_alu_ctrl, m_alu_a, m_alu_b}) begin
        errors++; $display("FAIL ill_alu_hold: got %b %0h %0h expected %b %0h %0h",
                           alu_ctrl, alu_a, alu_b, m_alu_ctrl, m_alu_a, m_alu_b);
      end
      finish_resp();
    end
  endtask

  task automatic test_random();
    int id, h, r, exp_id, stall;
    resp_t exp;
    logic lg;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(1) == 1)
          set_req(i, ($urandom_range(3) == 0) ? rand_illegal() : rand_legal(), $urandom, $urandom);
      end
      if (req_valid == '0) set_req(int'($urandom_range(NR - 1)), rand_legal(), $urandom, $urandom);
      resp_ready = 1'b0;
      exp_id = model_grant(req_valid, model_last);
      lg  = is_legal(p_ctrl[exp_id]);
      exp = model_resp(p_ctrl[exp_id], p_a[exp_id], p_b[exp_id]);
      if (lg) {m_alu_ctrl, m_alu_a, m_alu_b} = {p_ctrl[exp_id], p_a[exp_id], p_b[exp_id]};
      model_last = exp_id;
      wait_hs(id, h);
      checks++;
      if (id != exp_id) begin
        errors++; $display("FAIL rnd_grant: got %0d expected %0d", id, exp_id);
        if (id < 0) req_valid[exp_id] = 1'b0;
      end
      wait_resp(r);
      checks++;
      if (h < 0 || r - h != (lg ? 2 : 1)) begin
        errors++; $display("FAIL rnd_latency: got %0d expected %0d", r - h, lg ? 2 : 1);
      end
      checks++;
      if ({resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err} !== {IW'(exp_id), exp}) begin
        errors++; $display("FAIL rnd_resp: got id %0d c %0h flags %b%b%b%b expected id %0d c %0h flags %b%b%b%b",
                           resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err,
                           exp_id, exp.c, exp.zero, exp.over, exp.cout, exp.err);
      end
      checks++;
      if ({alu_ctrl, alu_a, alu_b} !== {m_alu_ctrl, m_alu_a, m_alu_b}) begin
        errors++; $display("FAIL rnd_alu: got %b %0h %0h expected %b %0h %0h",
                           alu_ctrl, alu_a, alu_b, m_alu_ctrl, m_alu_a, m_alu_b);
      end
      stall = int'($urandom_range(3));
      if (stall > 0) begin
        repeat (stall) begin @(negedge clk); #1; end
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== '0 || resp_c !== exp.c) begin
          errors++; $display("FAIL rnd_stall: got v%b rdy %b c %0h expected v1 rdy 0 c %0h",
                             resp_valid, req_ready, resp_c, exp.c);
        end
      end
      finish_resp();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_exec();
    int id, h, r;
    resp_ready = 1'b1;
    set_req(3, OP_ADD, $urandom, $urandom);
    wait_hs(id, h);
    set_req(1, rand_legal(), $urandom, $urandom);
    set_req(2, rand_legal(), $urandom, $urandom);
    #1 rst_n = 1'b0;
    #1;
    model_last = NR - 1;
    {m_alu_ctrl, m_alu_a, m_alu_b} = '0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL rst_exec_hs: got v%b rdy %b expected v0 rdy 0", resp_valid, req_ready);
    end
    checks++;
    if ({resp_id, resp_c, resp_zero, resp_over, resp_cout, resp_err, alu_ctrl, alu_a, alu_b} !== '0) begin
      errors++; $display("FAIL rst_exec_outputs: id %0d c %0h alu %b %0h %0h expected all 0",
                         resp_id, resp_c, alu_ctrl, alu_a, alu_b);
    end
    @(negedge clk);
    set_req(0, OP_OR, $urandom, $urandom);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_release: got v%b rdy %b expected v0 rdy 0001", resp_valid, req_ready);
    end
    {m_alu_ctrl, m_alu_a, m_alu_b} = {p_ctrl[0], p_a[0], p_b[0]};
    model_last = 0;
    wait_hs(id, h);
    checks++;
    if (id != 0) begin errors++; $display("FAIL rst_first_grant: got %0d expected 0", id); end
    wait_resp(r);
    checks++;
    if (h < 0 || r - h != 2 || resp_id !== 2'd0 || resp_c !== (p_a[0] | p_b[0])) begin
      errors++; $display("FAIL rst_first_resp: latency %0d id %0d c %0h expected 2 id 0 c %0h",
                         r - h, resp_id, resp_c, p_a[0] | p_b[0]);
    end
    finish_resp();
    req_valid = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_ctrl   = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_add();
    test_sub_zero();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid_exec();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between `NUM_REQ` requesters (integer pipe, branch compare unit, address generator, debug port) using a round-robin arbiter with valid/ready handshakes. Each accepted request is registered, driven onto the ALU for one full cycle, and its result is captured and returned on a single tagged response port with backpressure. Opcodes the ALU does not implement are trapped and answered with an error flag; they are never issued.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width.
- `CTRL_BITS`, default 4: ALU opcode width.
- `NUM_REQ`, default 4: number of requesters. Must be at least 2.
- `ID_W`, default `$clog2(NUM_REQ)`: response tag width.

Ports (clock and reset first; requester `i` occupies slice `i` of each flattened bus):
- `clk`  in  1  system clock. One clock domain, rising edge.
- `rst_n`  in  1  reset. Asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept. At most one bit is high.
- `req_ctrl`  in  NUM_REQ*CTRL_BITS  per-requester opcode.
- `req_a`, `req_b`  in  NUM_REQ*DATA_WIDTH each  per-requester operands.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response consumer accept.
- `resp_id`  out  ID_W  index of the requester that owns the response.
- `resp_c`  out  DATA_WIDTH  result.
- `resp_zero`, `resp_over`, `resp_cout`  out  1 each  ALU flags.
- `resp_err`  out  1  illegal opcode.
- `alu_ctrl`  out  CTRL_BITS  drives the ALU opcode input.
- `alu_a`, `alu_b`  out  DATA_WIDTH each  drive the ALU operand inputs.
- `alu_c`  in  DATA_WIDTH  ALU result.
- `alu_zero`, `alu_over`, `alu_c_out`  in  1 each  ALU flags.

## Operation
State machine: IDLE, EXEC, RESP.

**IDLE**
- Grant goes to the first requester with `req_valid` high. The search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
- `req_ready[grant]` is asserted combinationally. It is asserted only in IDLE and only while `rst_n` is high.
- On the edge where `req_valid & req_ready` is true:
  - latch `ctrl`, `a`, `b` into the operand registers;
  - latch the grant index into the ID register;
  - update `last_grant` to the grant index.
- If the opcode is legal, go to EXEC.
- If the opcode is illegal, load the result register with c=0, zero=0, over=0, cout=0, err=1, and go directly to RESP.

**Legal opcodes:** AND 0000, OR 0011, ADD 0010, SUB 0110, SLT 0111, SGE 0101, NOR 1100. Every other encoding is illegal, including 0001 and 1111.

**EXEC**
- `alu_ctrl`, `alu_a`, `alu_b` are driven from the operand registers and are stable for the whole cycle.
- At the end of the cycle, capture `alu_c`, `alu_zero`, `alu_over`, `alu_c_out` into the result register, with err=0.
- Go to RESP.

**RESP**
- `resp_valid` is 1. All `resp_*` fields come from the result register and are held stable.
- On `resp_valid & resp_ready`, go to IDLE.
- While stalled, no new request is accepted.

**Other rules**
- `alu_*` outputs are driven from the operand registers at all times and hold the last issued values between operations. Illegal opcodes never reach the operand registers' ALU drive path; `alu_ctrl` keeps its previous value.
- Reset, asynchronous, at any time including mid-EXEC or mid-RESP:
  - state goes to IDLE and any in-flight operation is discarded;
  - `last_grant` = `NUM_REQ-1`, so requester 0 wins first;
  - operand, ID and result registers = 0;
  - `resp_valid` = 0 and `req_ready` = 0.
- Reset values of outputs: `req_ready` 0, `resp_valid` 0, `resp_id` 0, `resp_c` 0, all flags 0, `alu_ctrl` 0000, `alu_a` 0, `alu_b` 0.

## Timing
- **Legal op:** accepted at edge T, driven to the ALU during cycle T..T+1, `resp_valid` high from T+2. Latency from accept to response is 2 cycles.
- **Illegal op:** `resp_valid` high from T+1.
- **Throughput:** at best one legal op every 3 cycles (accept, EXEC, RESP handshake), and one every 2 cycles for illegal ops.
- **Handshake:** the earliest next accept is the cycle after the RESP handshake.
- **Request side:** a requester must hold `req_valid`, `req_ctrl`, `req_a`, `req_b` stable until `req_ready`. The arbiter never revokes a grant within the IDLE cycle.
- **Simultaneous events:** the RESP handshake and a new `req_valid` in the same cycle cause no accept that cycle; the accept happens the next cycle.
- **Fairness:** with all requesters continuously valid, grants rotate strictly 0,1,…,NUM_REQ-1,0.

## Test plan
- **Single ADD:** requester 0 sends ADD, a=75, b=25, resp_ready=1. Expect resp_valid exactly 2 cycles after accept, resp_id=0, resp_c=100, zero=0, over=0, err=0.
- **SUB to zero:** requester 2 sends SUB 1−1. Expect resp_c=0, zero=1, cout=1, resp_id=2. Then ADD 0x80000000+0x80000000: expect resp_c=0, over=1, cout=1, zero=1.
- **Round-robin:** all 4 requesters valid continuously with distinct operands. Expect response IDs 0,1,2,3,0,1 and each result matching its own operands.
- **Backpressure:** resp_ready=0 for 5 cycles during RESP. Expect resp fields stable, req_ready all 0 and alu_* unchanged. Accept occurs the cycle after resp_ready rises.
- **Illegal opcode:** requester 1 sends ctrl=1111, a=5, b=3. Expect resp_valid 1 cycle after accept, resp_c=0, err=1, and alu_ctrl unchanged from the previous op.
- **Reset mid-EXEC:** drop rst_n during EXEC. Expect resp_valid=0 and all outputs at reset values immediately. After release, requester 0 is granted first and no stale response appears.
